// File: rtl/conv_res_collector.sv
// conv_res_collector: takes the accelerator's frame-wide result vector in a
// single post handshake, replays it one word per beat on a valid/ready
// stream, tracks the argmax while draining and counts completed frames.
module conv_res_collector #(
  parameter int NUM_CLASS = 10,
  parameter int RES_W     = 32,
  parameter int CNT_W     = 16,
  parameter int IDX_W     = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_post_valid,
  output logic                            o_post_ready,
  input  logic [NUM_CLASS-1:0][RES_W-1:0] i_res,
  output logic                            o_m_valid,
  input  logic                            i_m_ready,
  output logic [RES_W-1:0]                o_m_data,
  output logic [IDX_W-1:0]                o_m_idx,
  output logic                            o_m_last,
  output logic                            o_cls_valid,
  output logic [IDX_W-1:0]                o_cls_idx,
  output logic [RES_W-1:0]                o_cls_score,
  output logic [CNT_W-1:0]                o_frame_cnt
);

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_e;

  state_e                          state_q;
  logic [NUM_CLASS-1:0][RES_W-1:0] cap_q;
  logic [IDX_W-1:0]                idx_q;
  logic [IDX_W-1:0]                best_idx_q;
  logic [RES_W-1:0]                best_score_q;
  logic [IDX_W-1:0]                cls_idx_q;
  logic [RES_W-1:0]                cls_score_q;
  logic                            cls_valid_q;
  logic [CNT_W-1:0]                cnt_q;

  logic [RES_W-1:0]                cur_word;
  logic                            idx_is_last;
  logic                            take_cur;
  logic [IDX_W-1:0]                best_idx_d;
  logic [RES_W-1:0]                best_score_d;

  // Running-best update for the word currently on the stream; strict compare
  // keeps the lowest index on ties, and index 0 always seeds the search.
  always_comb begin
    cur_word     = cap_q[idx_q];
    idx_is_last  = (idx_q == IDX_W'(NUM_CLASS - 1));
    take_cur     = (idx_q == '0) || ($signed(cur_word) > $signed(best_score_q));
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    if (take_cur) begin
      best_idx_d   = idx_q;
      best_score_d = cur_word;
    end
  end

  // Control FSM, capture buffer, argmax tracking and frame counter.
  // The final result is copied into separate cls registers so the reported
  // argmax holds steady while the next frame's running search proceeds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cap_q        <= '0;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      cls_idx_q    <= '0;
      cls_score_q  <= '0;
      cls_valid_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      cls_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_post_valid) begin
            cap_q   <= i_res;
            idx_q   <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_m_ready) begin
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            if (idx_is_last) begin
              state_q     <= S_IDLE;
              cls_idx_q   <= best_idx_d;
              cls_score_q <= best_score_d;
              cls_valid_q <= 1'b1;
              cnt_q       <= cnt_q + CNT_W'(1);
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_post_ready = (state_q == S_IDLE);
  assign o_m_valid    = (state_q == S_DRAIN);
  assign o_m_data     = cur_word;
  assign o_m_idx      = idx_q;
  assign o_m_last     = (state_q == S_DRAIN) && idx_is_last;
  assign o_cls_valid  = cls_valid_q;
  assign o_cls_idx    = cls_idx_q;
  assign o_cls_score  = cls_score_q;
  assign o_frame_cnt  = cnt_q;

endmodule

// File: tb/tb_conv_res_collector.sv
// Testbench for conv_res_collector: table of directed frames, hand-written
// back-to-back and reset-mid-drain sequences, then randomized frames checked
// against a max-then-first-index reference and a modulo frame counter.
module tb_conv_res_collector;

  localparam int NC = 10;
  localparam int RW = 32;
  localparam int CW = 2;
  localparam int IW = 4;

  typedef logic [NC-1:0][RW-1:0] vec_t;

  typedef struct {
    vec_t        v;
    int          mode;
    int          eidx;
    logic [31:0] escore;
  } vec_rec_t;

  logic          clk;
  logic          rst_n;
  logic          post_valid;
  logic          post_ready;
  vec_t          res;
  logic          m_valid;
  logic          m_ready;
  logic [RW-1:0] m_data;
  logic [IW-1:0] m_idx;
  logic          m_last;
  logic          cls_valid;
  logic [IW-1:0] cls_idx;
  logic [RW-1:0] cls_score;
  logic [CW-1:0] frame_cnt;

  int checks   = 0;
  int failures = 0;
  int mcnt     = 0;

  conv_res_collector #(
    .NUM_CLASS(NC),
    .RES_W    (RW),
    .CNT_W    (CW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_post_valid(post_valid),
    .o_post_ready(post_ready),
    .i_res       (res),
    .o_m_valid   (m_valid),
    .i_m_ready   (m_ready),
    .o_m_data    (m_data),
    .o_m_idx     (m_idx),
    .o_m_last    (m_last),
    .o_cls_valid (cls_valid),
    .o_cls_idx   (cls_idx),
    .o_cls_score (cls_score),
    .o_frame_cnt (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference argmax: find the largest signed value, then the first index holding it.
  function automatic void ref_argmax(input vec_t v, output int bi, output logic [31:0] bs);
    int mx;
    mx = $signed(v[0]);
    for (int i = 1; i < NC; i++) if ($signed(v[i]) > mx) mx = $signed(v[i]);
    bi = -1;
    for (int i = NC - 1; i >= 0; i--) if ($signed(v[i]) == mx) bi = i;
    bs = mx;
  endfunction

  task automatic start_frame(input vec_t v);
    int n;
    n = 0;
    while (!post_ready && n < 50) begin
      step();
      n++;
    end
    post_valid = 1'b1;
    res        = v;
    step();
  endtask

  // Called one cycle after the accepting edge; walks the stream to the pulse.
  task automatic drain(input vec_t v, input int mode, input int eidx, input logic [31:0] escore,
                       input bit hold_next, input vec_t nv);
    int e;
    int cyc;
    e   = 0;
    cyc = 0;
    post_valid = hold_next;
    if (hold_next) res = nv;
    while (e < NC && cyc < 400) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 2) == 1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      chk("m_valid", 64'(m_valid), 64'd1);
      chk("m_data", 64'(m_data), 64'(v[e]));
      chk("m_idx", 64'(m_idx), 64'(e));
      chk("m_last", 64'(m_last), 64'(e == NC - 1));
      chk("cls_quiet", 64'(cls_valid), 64'd0);
      chk("post_ready_drain", 64'(post_ready), 64'd0);
      if (m_ready) e++;
      step();
      cyc++;
    end
    if (e < NC) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d beats required=%0d", e, NC);
    end
    mcnt++;
    m_ready = 1'b0;
    chk("cls_valid", 64'(cls_valid), 64'd1);
    chk("cls_idx", 64'(cls_idx), 64'(eidx));
    chk("cls_score", 64'(cls_score), 64'(escore));
    chk("frame_cnt", 64'(frame_cnt), 64'(mcnt % (1 << CW)));
    chk("post_ready_pulse", 64'(post_ready), 64'd1);
    chk("m_valid_idle", 64'(m_valid), 64'd0);
    if (!hold_next) begin
      step();
      chk("cls_pulse_end", 64'(cls_valid), 64'd0);
      chk("cls_idx_hold", 64'(cls_idx), 64'(eidx));
      chk("cls_score_hold", 64'(cls_score), 64'(escore));
      chk("post_ready_idle", 64'(post_ready), 64'd1);
    end
  endtask

  task automatic frame(input vec_t v, input int mode, input int eidx, input logic [31:0] escore);
    start_frame(v);
    drain(v, mode, eidx, escore, 1'b0, v);
  endtask

  vec_rec_t    tbl[5];
  vec_t        va, vb, vr;
  int          ridx;
  logic [31:0] rscore;

  initial begin
    // Directed table
    for (int i = 0; i < NC; i++) tbl[0].v[i] = '0;
    tbl[0].v[0] = 32'd5;
    tbl[0].v[1] = 32'd9;
    tbl[0].v[2] = 32'd3;
    tbl[0].v[3] = 32'd9;
    tbl[0].mode = 0; tbl[0].eidx = 1; tbl[0].escore = 32'd9;
    tbl[1].v = tbl[0].v;
    tbl[1].mode = 1; tbl[1].eidx = 1; tbl[1].escore = 32'd9;
    for (int i = 0; i < NC; i++) tbl[2].v[i] = 32'hFFFF_FFFF;
    tbl[2].v[7] = 32'hFFFF_FF9C;
    tbl[2].mode = 0; tbl[2].eidx = 0; tbl[2].escore = 32'hFFFF_FFFF;
    for (int i = 0; i < NC; i++) tbl[3].v[i] = 32'd42;
    tbl[3].mode = 0; tbl[3].eidx = 0; tbl[3].escore = 32'd42;
    for (int i = 0; i < NC; i++) tbl[4].v[i] = 32'hFFFF_FFFB;
    tbl[4].v[6] = 32'd3;
    tbl[4].v[8] = 32'h8000_0000;
    tbl[4].mode = 2; tbl[4].eidx = 6; tbl[4].escore = 32'd3;

    rst_n      = 1'b0;
    post_valid = 1'b0;
    m_ready    = 1'b0;
    res        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_idx", 64'(m_idx), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_cls_valid", 64'(cls_valid), 64'd0);
    chk("rst_cls_idx", 64'(cls_idx), 64'd0);
    chk("rst_cls_score", 64'(cls_score), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_post_ready", 64'(post_ready), 64'd1);
    chk("idle_m_valid", 64'(m_valid), 64'd0);

    for (int k = 0; k < 5; k++) frame(tbl[k].v, tbl[k].mode, tbl[k].eidx, tbl[k].escore);

    // Back-to-back: second vector accepted in the first frame's pulse cycle
    for (int i = 0; i < NC; i++) begin
      va[i] = 32'(i * 3);
      vb[i] = 32'(i);
    end
    vb[4] = 32'd100;
    start_frame(va);
    drain(va, 0, 9, 32'd27, 1'b1, vb);
    chk("b2b_valid_held", 64'(post_valid), 64'd1);
    step();
    drain(vb, 0, 4, 32'd100, 1'b0, vb);

    // Reset in the middle of a drain abandons the frame
    start_frame(tbl[0].v);
    post_valid = 1'b0;
    m_ready    = 1'b1;
    repeat (4) step();
    chk("pre_rst_idx", 64'(m_idx), 64'd4);
    rst_n = 1'b0;
    #1;
    m_ready = 1'b0;
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_m_data", 64'(m_data), 64'd0);
    chk("mid_rst_m_idx", 64'(m_idx), 64'd0);
    chk("mid_rst_cls_valid", 64'(cls_valid), 64'd0);
    chk("mid_rst_cls_idx", 64'(cls_idx), 64'd0);
    chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    mcnt = 0;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_ready", 64'(post_ready), 64'd1);
      chk("post_rst_cls_valid", 64'(cls_valid), 64'd0);
      chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    end

    // Randomized frames; counter wraps at 4
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < NC; i++) begin
        if (f % 2 == 0) vr[i] = $urandom();
        else            vr[i] = 32'($signed($urandom_range(0, 7)) - 4);
      end
      ref_argmax(vr, ridx, rscore);
      frame(vr, 2, ridx, rscore);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_res_collector.md
Name: conv_res_collector

Overview:
- Downstream partner on the accelerator's result (post) handshake: it is the consumer that drives the accelerator's post-ready and takes the frame-wide result vector when post-valid is high.
- Captures all NUM_CLASS results in one handshake and replays them as a one-word-per-beat valid/ready stream.
- Computes the argmax class and score on the fly while draining.
- Maintains a completed-frame counter.
- Sits between the conv accelerator top and the system output / host interface.

Parameters:
- NUM_CLASS, 10, number of result words per frame (must be ≥1).
- RES_W, 32, width of each result word; words are treated as two's-complement signed.
- CNT_W, 16, width of the frame counter.
- IDX_W, max(1, $clog2(NUM_CLASS)), derived; width of index outputs.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_post_valid  in  1  result vector valid (driven by the accelerator's post-valid).
- o_post_ready  out  1  collector can accept a vector (drives the accelerator's post-ready).
- i_res  in  [NUM_CLASS-1:0][RES_W-1:0]  result vector; sampled only on handshake.
- o_m_valid  out  1  stream word valid.
- i_m_ready  in  1  stream sink ready.
- o_m_data  out  RES_W  stream word, equal to buf[o_m_idx].
- o_m_idx  out  IDX_W  class index of the current word.
- o_m_last  out  1  high on the beat where o_m_idx == NUM_CLASS-1.
- o_cls_valid  out  1  one-cycle pulse when the argmax is final.
- o_cls_idx  out  IDX_W  argmax index.
- o_cls_score  out  RES_W  argmax value.
- o_frame_cnt  out  CNT_W  number of completed frames; wraps modulo 2^CNT_W.

Behaviour:

Reset (i_rst_n low, asynchronous):
- State goes to IDLE.
- All outputs are 0 except o_post_ready, which is 1 once in IDLE.
- Capture buffer, index, best registers and counter are cleared.
- Reset mid-DRAIN abandons the frame: no o_cls_valid pulse, counter unchanged.

State IDLE:
- o_post_ready = 1, o_m_valid = 0.
- On i_post_valid & o_post_ready: latch all of i_res into buf; set idx = 0; go to DRAIN.
- The upstream source must hold i_res stable while valid; only the handshake edge matters.

State DRAIN:
- o_post_ready = 0, so no new vector is accepted during a drain.
- o_m_valid = 1; o_m_data, o_m_idx and o_m_last are registered/decoded from idx.
- Outputs must hold stable while o_m_valid & !i_m_ready.
- On each beat (o_m_valid & i_m_ready):
  - If idx == 0, or $signed(buf[idx]) > $signed(best_score): best_score = buf[idx], best_idx = idx. The strict compare means ties go to the lowest index.
  - If o_m_last: go to IDLE. The next cycle has o_cls_valid = 1 with the final best_idx/best_score, and o_frame_cnt increments (2^CNT_W-1 wraps to 0).
  - Otherwise idx increments.
- The final beat's comparison is included in o_cls_idx/o_cls_score.

Timing and edge cases:
- Latency: handshake at edge k → o_m_valid high after edge k. With i_m_ready held high, the last beat is at edge k+NUM_CLASS and the o_cls_valid pulse follows that edge.
- A new post handshake is allowed in the same cycle as the o_cls_valid pulse (IDLE, ready = 1). Minimum frame period is NUM_CLASS+1 cycles.
- o_cls_idx and o_cls_score hold their value after the pulse until the next frame's final beat.
- NUM_CLASS = 1: the first beat is also last.
- i_m_ready toggling is legal at any time. i_post_valid high while o_post_ready = 0 is ignored; the upstream source must keep it asserted.

Test Plan:
1. Reset release, i_res = {0:5, 1:9, 2:3, 3:9, 4..9:0}, i_post_valid 1 cycle, i_m_ready = 1 → o_post_ready drops next cycle. 10 beats: data 5, 9, 3, 9, 0, … with o_m_last on idx 9. Then o_cls_valid pulse with idx = 1, score = 9, and o_frame_cnt = 1.
2. Backpressure: same vector, i_m_ready low on every other cycle → data and idx stable while stalled. 10 beats in order; same argmax; pulse only after the 10th beat.
3. Signed values: all words 32'hFFFFFFFF (−1) except idx 7 = −100 → o_cls_idx = 0, o_cls_score = −1. All words equal 42 → idx 0.
4. Back-to-back frames: i_post_valid held high with two vectors, max at idx 9 then idx 4 → the second is accepted in the pulse cycle of the first (11-cycle period). Pulses report 9 then 4; o_frame_cnt = 2.
5. Reset mid-drain: assert i_rst_n low after beat 4 → outputs 0 immediately. After release: o_post_ready = 1, o_frame_cnt = 0, no o_cls_valid pulse. A fresh frame then completes normally.
6. Counter wrap (CNT_W = 2): run 5 frames → o_frame_cnt goes 1, 2, 3, 0, 1.
